// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event classifier.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HELD
  } state_t;

  localparam int unsigned EVT_CNT_W = 8;

endpackage

// File: rtl/button_event_classifier_ms_tick_timer.sv
// Prescaled tick timer: a tick every TICK_DIV cycles, counted in cnt.
// clr restarts both the prescaler and the tick count.
module ms_tick_timer #(
  parameter int TICK_DIV = 50000,
  parameter int W        = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic         tick,
  output logic [W-1:0] cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  // Prescaler and tick counter, both cleared on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (clr) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short, long and double-click
// events with registered one-cycle pulses and a wrapping event counter.
module button_event_classifier
  import button_event_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 800,
  parameter int DCLICK_MS = 300,
  parameter int W         = 10
) (
  input  logic                 ButtonEvt_CLOCK_50,
  input  logic                 ButtonEvt_Reset_InLow,
  input  logic                 ButtonEvt_Button_In,
  output logic                 ButtonEvt_Press_Pulse,
  output logic                 ButtonEvt_Short_Pulse,
  output logic                 ButtonEvt_Long_Pulse,
  output logic                 ButtonEvt_Double_Pulse,
  output logic                 ButtonEvt_Held,
  output logic [EVT_CNT_W-1:0] ButtonEvt_Event_Count
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end
  if (LONG_MS < 1 || LONG_MS > (2**W) - 1) begin : g_bad_long_ms
    $error("LONG_MS must be in 1..2^W-1");
  end
  if (DCLICK_MS < 1 || DCLICK_MS > (2**W) - 1) begin : g_bad_dclick_ms
    $error("DCLICK_MS must be in 1..2^W-1");
  end

  localparam logic [W-1:0] LONG_LAST   = W'(LONG_MS - 1);
  localparam logic [W-1:0] DCLICK_LAST = W'(DCLICK_MS - 1);

  state_t               state, nxt;
  logic                 trans;
  logic                 prev_in, rise, fall;
  logic                 tick;
  logic [W-1:0]         tcnt;
  logic                 to_long, to_dclick;
  logic                 press_d, short_d, long_d, dbl_d;
  logic                 press_q, short_q, long_q, dbl_q, held_q;
  logic [EVT_CNT_W-1:0] evt_cnt;

  assign rise      = ButtonEvt_Button_In & ~prev_in;
  assign fall      = ~ButtonEvt_Button_In & prev_in;
  assign to_long   = tick && (tcnt == LONG_LAST);
  assign to_dclick = tick && (tcnt == DCLICK_LAST);

  // One timer shared by all states, restarted on every transition.
  ms_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .W        (W)
  ) u_timer (
    .clk   (ButtonEvt_CLOCK_50),
    .rst_n (ButtonEvt_Reset_InLow),
    .clr   (trans),
    .tick  (tick),
    .cnt   (tcnt)
  );

  // State register.
  always_ff @(posedge ButtonEvt_CLOCK_50 or negedge ButtonEvt_Reset_InLow) begin
    if (!ButtonEvt_Reset_InLow) state <= IDLE;
    else                        state <= nxt;
  end

  // Next-state decision; trans flags any transition, re-entry included.
  always_comb begin
    nxt   = state;
    trans = 1'b0;
    unique case (state)
      IDLE: if (rise) begin nxt = PRESS1; trans = 1'b1; end
      PRESS1: begin
        if (to_long)   begin nxt = LONG_HELD; trans = 1'b1; end
        else if (fall) begin nxt = WAIT2;     trans = 1'b1; end
      end
      WAIT2: begin
        // A rise coinciding with the window expiry starts a fresh press.
        if (to_dclick) begin nxt = rise ? PRESS1 : IDLE; trans = 1'b1; end
        else if (rise) begin nxt = PRESS2; trans = 1'b1; end
      end
      PRESS2: begin
        if (fall)         begin nxt = IDLE;      trans = 1'b1; end
        else if (to_long) begin nxt = LONG_HELD; trans = 1'b1; end
      end
      LONG_HELD: if (fall) begin nxt = IDLE; trans = 1'b1; end
      default: begin nxt = IDLE; trans = 1'b1; end
    endcase
  end

  // Event decisions for the current cycle, registered below.
  always_comb begin
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    unique case (state)
      IDLE:   press_d = rise;
      PRESS1: long_d  = to_long;
      WAIT2: begin
        short_d = to_dclick;
        press_d = rise;
      end
      PRESS2: dbl_d = fall | to_long;
      default: ;
    endcase
  end

  // Registered outputs, edge-detect history and event counter.
  always_ff @(posedge ButtonEvt_CLOCK_50 or negedge ButtonEvt_Reset_InLow) begin
    if (!ButtonEvt_Reset_InLow) begin
      prev_in <= 1'b0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
      evt_cnt <= '0;
    end else begin
      prev_in <= ButtonEvt_Button_In;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= (nxt == LONG_HELD);
      if (short_d | long_d | dbl_d) evt_cnt <= evt_cnt + EVT_CNT_W'(1);
    end
  end

  assign ButtonEvt_Press_Pulse  = press_q;
  assign ButtonEvt_Short_Pulse  = short_q;
  assign ButtonEvt_Long_Pulse   = long_q;
  assign ButtonEvt_Double_Pulse = dbl_q;
  assign ButtonEvt_Held         = held_q;
  assign ButtonEvt_Event_Count  = evt_cnt;

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: directed gestures with literal
// expectations plus randomized button activity against a gesture model.
module tb_button_event_classifier;

  localparam int TD  = 4;
  localparam int LMS = 5;
  localparam int DMS = 3;
  localparam int LONG_CYC   = LMS * TD;
  localparam int DCLICK_CYC = DMS * TD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       press, short_p, long_p, dbl, held;
  logic [7:0] ecnt;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  always #5 clk = ~clk;

  button_event_classifier #(
    .TICK_DIV  (TD),
    .LONG_MS   (LMS),
    .DCLICK_MS (DMS),
    .W         (10)
  ) dut (
    .ButtonEvt_CLOCK_50     (clk),
    .ButtonEvt_Reset_InLow  (rst_n),
    .ButtonEvt_Button_In    (btn),
    .ButtonEvt_Press_Pulse  (press),
    .ButtonEvt_Short_Pulse  (short_p),
    .ButtonEvt_Long_Pulse   (long_p),
    .ButtonEvt_Double_Pulse (dbl),
    .ButtonEvt_Held         (held),
    .ButtonEvt_Event_Count  (ecnt)
  );

  // Gesture model: phase plus elapsed cycles since the phase was entered.
  // Phases: 0 idle, 1 first press, 2 release window, 3 second press, 4 held.
  typedef struct packed {
    int         ph;
    int         age;
    bit         prev;
    bit         p, s, l, d, h;
    logic [7:0] cnt;
  } model_t;

  model_t m = '0;

  function automatic model_t step(input model_t c, input bit b);
    model_t n;
    int el;
    bit r, f, tl, tdc;
    n = c;
    el  = c.age + 1;
    r   = b & ~c.prev;
    f   = ~b & c.prev;
    tl  = (el == LONG_CYC);
    tdc = (el == DCLICK_CYC);
    n.p = 1'b0; n.s = 1'b0; n.l = 1'b0; n.d = 1'b0;
    case (c.ph)
      0: if (r) begin n.p = 1'b1; n.ph = 1; end
      1: if (tl) begin n.l = 1'b1; n.ph = 4; end
         else if (f) n.ph = 2;
      2: if (tdc) begin n.s = 1'b1; n.p = r; n.ph = r ? 1 : 0; end
         else if (r) begin n.p = 1'b1; n.ph = 3; end
      3: if (f) begin n.d = 1'b1; n.ph = 0; end
         else if (tl) begin n.d = 1'b1; n.ph = 4; end
      default: if (f) n.ph = 0;
    endcase
    n.age  = (n.ph != c.ph) ? 0 : el;
    n.prev = b;
    n.h    = (n.ph == 4);
    n.cnt  = c.cnt + ((n.s | n.l | n.d) ? 8'd1 : 8'd0);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, btn);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Every cycle, DUT outputs versus the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("press",  {7'd0, press},   {7'd0, m.p});
      chk("short",  {7'd0, short_p}, {7'd0, m.s});
      chk("long",   {7'd0, long_p},  {7'd0, m.l});
      chk("double", {7'd0, dbl},     {7'd0, m.d});
      chk("held",   {7'd0, held},    {7'd0, m.h});
      chk("count",  ecnt,            m.cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    btn   = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", ecnt, 8'd0);
    chk("rst_held", {7'd0, held}, 8'd0);

    // Short press: 8 cycles pressed, then release.
    btn = 1'b1; cyc(1);
    chk("short_press_pulse", {7'd0, press}, 8'd1);
    cyc(7);
    btn = 1'b0; cyc(1);
    cyc(11);
    chk("short_early", {7'd0, short_p}, 8'd0);
    cyc(1);
    chk("short_pulse", {7'd0, short_p}, 8'd1);
    chk("short_count", ecnt, 8'd1);
    cyc(8);
    do_reset();

    // Long press: held well past the threshold.
    btn = 1'b1; cyc(1);
    cyc(19);
    chk("long_early", {7'd0, long_p}, 8'd0);
    cyc(1);
    chk("long_pulse", {7'd0, long_p}, 8'd1);
    cyc(1);
    chk("long_held", {7'd0, held}, 8'd1);
    cyc(8);
    btn = 1'b0; cyc(1);
    chk("long_unheld", {7'd0, held}, 8'd0);
    chk("long_count", ecnt, 8'd1);
    cyc(5);
    do_reset();

    // Double click.
    btn = 1'b1; cyc(5);
    btn = 1'b0; cyc(6);
    btn = 1'b1; cyc(5);
    btn = 1'b0; cyc(1);
    chk("double_pulse", {7'd0, dbl}, 8'd1);
    cyc(20);
    chk("double_count", ecnt, 8'd1);
    do_reset();

    // Second rise on the last cycle of the double-click window.
    btn = 1'b1; cyc(4);
    btn = 1'b0; cyc(1);
    cyc(11);
    btn = 1'b1; cyc(1);
    chk("edge_short", {7'd0, short_p}, 8'd1);
    chk("edge_press", {7'd0, press}, 8'd1);
    cyc(3);
    btn = 1'b0; cyc(13);
    chk("edge_count", ecnt, 8'd2);
    do_reset();

    // Release on the 20th cycle of the first press: long wins.
    btn = 1'b1; cyc(1);
    cyc(19);
    btn = 1'b0; cyc(1);
    chk("rel20_long", {7'd0, long_p}, 8'd1);
    chk("rel20_short", {7'd0, short_p}, 8'd0);
    cyc(20);

    // Button held through reset release.
    btn = 1'b1;
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(1);
    chk("held_rst_press", {7'd0, press}, 8'd1);
    cyc(1);
    btn = 1'b0; cyc(13);
    chk("held_rst_count", ecnt, 8'd1);

    // Reset in the middle of a press.
    btn = 1'b1; cyc(5);
    rst_n = 1'b0; #1;
    chk("midrst_count", ecnt, 8'd0);
    chk("midrst_press", {6'd0, press, short_p}, 8'd0);
    chk("midrst_other", {5'd0, long_p, dbl, held}, 8'd0);
    btn = 1'b0; cyc(3);
    rst_n = 1'b1; cyc(30);
    chk("midrst_after", ecnt, 8'd0);

    // Random button activity with occasional resets.
    for (int i = 0; i < 150; i++) begin
      btn = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 28));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1;
      end
    end

    // 256 short presses wrap the counter.
    btn = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1; cyc($urandom_range(1, 15));
      btn = 1'b0; cyc($urandom_range(13, 18));
      if (i == 254) chk("wrap_255", ecnt, 8'd255);
    end
    chk("wrap_0", ecnt, 8'd0);
    cyc(4);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
